// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared ASCII character codes, scheduler state encoding and
//               the round-robin index wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NUL   = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DELIM  = 2'd2,
        RESULT = 2'd3
    } state_t;

    // (base + k) mod n for base < n and k < n
    function automatic int wrap_idx(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; scans upward from the
//               pointer with wrap and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import parity_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_found
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_found && i_en && i_req[SW'(wrap_idx(int'(i_ptr), k, NREQ))]) begin
                o_found = 1'b1;
                o_grant[SW'(wrap_idx(int'(i_ptr), k, NREQ))] = 1'b1;
                o_id    = IDW'(wrap_idx(int'(i_ptr), k, NREQ));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parity_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_scheduler
// Description : Arbitrates NREQ word requesters onto one shared ASCII odd
//               parity generator and returns {word, parity} with the id.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_scheduler
    import parity_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    gen_reset,
    output logic [7:0]              gen_in,
    input  logic [7:0]              gen_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [WIDTH:0]          res_data,
    output logic                    res_err,
    output logic                    busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [WIDTH-1:0]   r_word;
    logic [BW-1:0]      r_idx;
    logic [IDW-1:0]     r_id;
    logic [WIDTH:0]     r_data;
    logic               r_err;

    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_gid;
    logic               w_found;
    logic [WIDTH-1:0]   w_words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_words[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    ((r_state == IDLE) && !reset),
        .o_grant (w_grant),
        .o_id    (w_gid),
        .o_found (w_found)
    );

    assign req_ready = w_grant;
    assign gen_reset = reset;
    assign res_valid = (r_state == RESULT);
    assign busy      = (r_state != IDLE);
    assign res_id    = r_id;
    assign res_data  = r_data;
    assign res_err   = r_err;

    // NUL outside the frame keeps the generator parked in S0
    always_comb begin
        gen_in = CH_NUL;
        case (r_state)
            SHIFT:   gen_in = r_word[r_idx] ? CH_ONE : CH_ZERO;
            DELIM:   gen_in = CH_SPACE;
            default: gen_in = CH_NUL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_word  <= '0;
            r_idx   <= '0;
            r_id    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_word  <= w_words[w_gid];
                        r_id    <= w_gid;
                        r_idx   <= BW'(WIDTH - 1);
                        r_ptr   <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_idx == '0) begin
                        r_state <= DELIM;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DELIM: begin
                    if (gen_out == CH_ONE) begin
                        r_data <= {r_word, 1'b1};
                        r_err  <= 1'b0;
                    end else if (gen_out == CH_ZERO) begin
                        r_data <= {r_word, 1'b0};
                        r_err  <= 1'b0;
                    end else begin
                        r_data <= {r_word, 1'b0};
                        r_err  <= 1'b1;
                    end
                    r_state <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/parity_frame_scheduler.md
Name: parity_frame_scheduler

Overview:
- Shares one external odd_parity_generator instance among NREQ requesters.
- Each requester offers a WIDTH-bit word over a valid/ready handshake; a round-robin arbiter picks one.
- The selected word is serialized MSB-first as ASCII '0'/'1' characters into the generator, followed by one ASCII space delimiter.
- The generator's parity character is captured and returned with the word and the requester id over a valid/ready result handshake.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width in bits (1..16).
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester word offered.
- req_data  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- gen_reset  output  1  reset to the generator; equals reset combinationally.
- gen_in  output  8  ASCII character driven to the generator.
- gen_out  input  8  ASCII character returned by the generator (combinational in the generator).
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_id  output  IDW  id of the requester whose word produced the result.
- res_data  output  WIDTH+1  {word, parity_bit}; parity bit in the LSB.
- res_err  output  1  delimiter response was neither '0' nor '1'.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: state IDLE, rr pointer 0, req_ready 0, gen_in 8'h00, res_valid 0, res_id 0, res_data 0, res_err 0, busy 0.
- FSM states: IDLE, SHIFT, DELIM, RESULT.
- IDLE:
  - gen_in = 8'h00 (NUL); this forces the generator counter to S0.
  - Grant the first requester with req_valid high, scanning from the rr pointer upward with wrap.
  - req_ready[grant] is high combinationally in that cycle. The handshake completes at that edge.
  - On handshake: latch word and id, set bit index to WIDTH-1, set rr pointer = grant+1 mod NREQ, go to SHIFT.
  - No valid requests: stay in IDLE.
- SHIFT:
  - gen_in = "1" if word[bit index] is 1, else "0".
  - Decrement the bit index each cycle; after index 0, go to DELIM. This takes exactly WIDTH cycles.
  - gen_out is ignored.
- DELIM:
  - gen_in = " " (8'h20), for one cycle.
  - Sample gen_out at the end of the cycle: "1" gives parity 1, "0" gives parity 0.
  - Any other value gives parity 0 and res_err 1.
  - The generator returns to S0 on the same edge. Go to RESULT.
- RESULT:
  - gen_in = 8'h00; res_valid = 1.
  - res_id, res_data and res_err are held stable until res_valid && res_ready at a clock edge, then go to IDLE.
  - Backpressure of any length is allowed.
- Latency: accept edge T; SHIFT cycles T+1..T+WIDTH; DELIM at T+WIDTH+1; res_valid high from T+WIDTH+2.
  - Minimum period between accepts: WIDTH+3 cycles.
- Parity: res_data[0] = 1 iff popcount(word) is even. The total count of ones in res_data is always odd. The generator counter is mod 4, so only its LSB matters.
- req_ready is 0 in every state except IDLE. req_valid that drops before being granted is not an error.
- A request held through a grant to another requester keeps its valid asserted and is served in rr order.
- Reset mid-operation: return to IDLE immediately; any in-flight word is discarded, res_valid drops, rr pointer goes to 0, and the generator is reset via gen_reset.
- res_err is a per-result flag, not sticky.

Decomposition:
- Shared package parity_pkg:
  - ASCII constants CH_ZERO = 8'h30, CH_ONE = 8'h31, CH_SPACE = 8'h20, CH_NUL = 8'h00.
  - FSM state encoding: IDLE = 0, SHIFT = 1, DELIM = 2, RESULT = 3.
- Sub-module rr_arbiter (NREQ, IDW):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded id.
- The parity generator is not instantiated inside this block; the testbench instantiates it and connects it alongside.

Test Plan:
- Requester 0 only, word 8'hA5 (popcount 4), res_ready = 1: gen_in sequence "1","0","1","0","0","1","0","1"," ", then res_valid at T+10 with res_data 9'h14B, res_id 0, res_err 0.
- Requester 2 only, word 8'h07 (popcount 3): res_data 9'h00E, res_id 2.
- Boundary words 8'h00 and 8'hFF, back-to-back: res_data 9'h001 then 9'h1FF; second accept at exactly T+11.
- All four requesters held valid continuously: grants in order 0, 1, 2, 3, 0; req_ready is one-hot and only in IDLE.
- res_ready held low 20 cycles in RESULT: outputs stable, req_ready stays 0, and the result is delivered on the first res_ready edge.
- Reset asserted during SHIFT on bit 3 of 8'hA5: next cycle all outputs at reset values. A following 8'h07 request produces 9'h00E with no residual count.
